motor_rodadas_param: RTL and testbench
======================================

// Module: motor_rodadas_param
// PURPOSE
//  Parametrised round/sequence engine for the Simon-style game. Generalises button count, sequence depth and scoring.
//  Reads the target sequence from an external sync-read ROM, validates one-hot button plays, grows the round by one
//  play per success, and adds a play timeout. Sits between the top-level game datapath/ROM and the score/display path.
// PARAMETERS
//  N_BOTOES     7     number of buttons; plays are one-hot over this width
//  DEPTH        16    sequence length = number of rounds
//  ADDR_W       4     ROM address width, >= $clog2(DEPTH)
//  TIMEOUT_CYC  5000  cycles allowed in ESPERA before timeout; 0 disables timeout
//  PTS_W        10    score width; score saturates at 2**PTS_W-1
// PORTS
//  clock        in   1         system clock, rising edge
//  reset        in   1         asynchronous, active-high
//  jogar        in   1         start/restart pulse; level-sampled
//  botoes       in   N_BOTOES  raw buttons, already synchronised
//  mem_dado     in   N_BOTOES  ROM data, valid 1 cycle after mem_addr
//  mem_addr     out  ADDR_W    ROM address = current play index
//  pronto       out  1         game over (success or failure), held until jogar
//  acertou      out  1         all DEPTH rounds completed
//  errou        out  1         wrong, non-one-hot or timed-out play
//  timeout      out  1         failure cause was timeout (implies errou)
//  pontos       out  PTS_W     accumulated score
//  rodada       out  ADDR_W+1  current round, 1..DEPTH
//  db_estado    out  4         FSM state code
// BEHAVIOUR
//  Reset: state INICIAL; all outputs 0; mem_addr=0; rodada=0.
//  FSM: INICIAL -jogar-> PREPARA (pontos=0, rodada=1, idx=0, flags cleared) -> LE_MEM (1 cycle, ROM latency)
//   -> ESPERA -> REGISTRA -> COMPARA.
//   COMPARA, jogada==mem_dado:
//    - idx<rodada-1: idx++ -> LE_MEM
//    - idx==rodada-1, rodada<DEPTH: FIM_RODADA
//    - rodada==DEPTH: ACERTOU
//   COMPARA, mismatch: ERROU.
//   FIM_RODADA (1 cycle): pontos+=rodada (saturating); rodada++; idx=0 -> LE_MEM.
//   ACERTOU: pontos+=DEPTH, then acertou=1, pronto=1.
//   ERROU: errou=1, pronto=1. Both terminal states exit to PREPARA on jogar.
//  Play detection in ESPERA:
//   - botoes must first be seen all-zero (release arming);
//   - a play is the first cycle with botoes!=0 after arming; that value is registered as jogada in REGISTRA;
//   - non-one-hot jogada (popcount!=1) counts as a mismatch.
//  Timeout: counter clears on entry to ESPERA; reaching TIMEOUT_CYC-1 with no play -> ERROU with timeout=1.
//  Simultaneous events: a play and timeout terminal count in the same cycle -> play wins.
//   jogar is ignored outside INICIAL/ACERTOU/ERROU.
//  Latency: press edge -> acertou/errou or next LE_MEM in 3 cycles (ESPERA->REGISTRA->COMPARA->next).
//  Width rules: rodada is ADDR_W+1 bits so DEPTH=2**ADDR_W fits; pontos add is PTS_W+1 wide, clamped.
//  Reset mid-operation: immediate return to INICIAL, all state lost.
// CONFIGURATION
//  MODO_TREINO_EN defined:
//   - adds input port `treinamento` (1 bit);
//   - when high, a mismatch/timeout pulses errou for 1 cycle, adds no points, sets idx=0 -> LE_MEM (replays round);
//     pronto is not set.
//  MODO_TREINO_EN undefined: no port; every failure is terminal as above.
// STRUCTURE
//  Package sinfonia_pkg: state codes (4-bit localparams, INICIAL=0 .. ERROU=9), popcount/one-hot function,
//   default parameter constants.
//  Sub-module detector_jogada: release arming, edge detection, one-hot check and timeout counter;
//   outputs jogada_valida, jogada, one_hot, estourou.
// TESTING
//  1 reset mid-round 3 -> all outputs 0, db_estado=0, mem_addr=0 next cycle.
//  2 jogar, then correct plays for rounds 1..16 (ROM 0x20,0x02,0x08,...) -> acertou=1, pronto=1, pontos=136+16=152.
//  3 round 2, press 0x04 where ROM=0x02 -> errou=1, pronto=1, timeout=0, pontos=1.
//  4 round 1, press 0x22 (two buttons) -> errou=1; press held across two waits counts once (no double play).
//  5 TIMEOUT_CYC=100, no press -> errou=1, timeout=1 exactly 100 cycles after ESPERA entry; press on cycle 99 -> play wins.
//  6 MODO_TREINO_EN, treinamento=1, wrong play in round 4 -> 1-cycle errou, rodada stays 4, pronto=0, pontos unchanged.

Source files
------------

// File: rtl/sinfonia_pkg.sv
// rtl/sinfonia_pkg.sv - state codes, default parameters and one-hot helper for the round engine
package sinfonia_pkg;

  localparam int N_BOTOES_DEF    = 7;
  localparam int DEPTH_DEF       = 16;
  localparam int ADDR_W_DEF      = 4;
  localparam int TIMEOUT_CYC_DEF = 5000;
  localparam int PTS_W_DEF       = 10;

  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    PREPARA    = 4'd1,
    LE_MEM     = 4'd2,
    ESPERA     = 4'd3,
    REGISTRA   = 4'd4,
    COMPARA    = 4'd5,
    FIM_RODADA = 4'd6,
    ACERTOU    = 4'd7,
    REPETE     = 4'd8,
    ERROU      = 4'd9
  } estado_t;

  // Button vectors are zero-extended to 32 bits before calling these.
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + {5'd0, v[i]};
    return n;
  endfunction

  function automatic logic is_one_hot(input logic [31:0] v);
    return popcount(v) == 6'd1;
  endfunction

endpackage

// File: rtl/detector_jogada.sv
// rtl/detector_jogada.sv - release arming, play capture, one-hot check and play timeout counter
module detector_jogada
  import sinfonia_pkg::*;
#(
  parameter int N_BOTOES    = N_BOTOES_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ativo,
  input  logic [N_BOTOES-1:0] botoes,
  output logic                jogada_valida,
  output logic [N_BOTOES-1:0] jogada,
  output logic                one_hot,
  output logic                estourou
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic             armado;
  logic [CNT_W-1:0] cnt;

  assign jogada_valida = ativo && armado && (botoes != '0);
  assign one_hot       = is_one_hot(32'(jogada));
  assign estourou      = ativo && (TIMEOUT_CYC != 0) && (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Leaving the wait state drops arming, so a button still held from the
  // previous play must be released before it can count again.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armado <= 1'b0;
      cnt    <= '0;
      jogada <= '0;
    end else if (!ativo) begin
      armado <= 1'b0;
      cnt    <= '0;
    end else begin
      if (botoes == '0) armado <= 1'b1;
      if (jogada_valida) begin
        jogada <= botoes;
        armado <= 1'b0;
      end
      if (!estourou) cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/motor_rodadas_param.sv
// rtl/motor_rodadas_param.sv - Simon round/sequence engine; MODO_TREINO_EN adds the training-replay input
module motor_rodadas_param
  import sinfonia_pkg::*;
#(
  parameter int N_BOTOES    = N_BOTOES_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int PTS_W       = PTS_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
`ifdef MODO_TREINO_EN
  input  logic                treinamento,
`endif
  input  logic [N_BOTOES-1:0] botoes,
  input  logic [N_BOTOES-1:0] mem_dado,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                pronto,
  output logic                acertou,
  output logic                errou,
  output logic                timeout,
  output logic [PTS_W-1:0]    pontos,
  output logic [ADDR_W:0]     rodada,
  output logic [3:0]          db_estado
);

  localparam int SUM_W = ((PTS_W > ADDR_W + 1) ? PTS_W : ADDR_W + 1) + 2;
  localparam logic [SUM_W-1:0] PTS_MAX = SUM_W'((64'd1 << PTS_W) - 64'd1);
  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);

  estado_t               estado, prox;
  logic [ADDR_W-1:0]     idx;
  logic [ADDR_W:0]       rod;
  logic [PTS_W-1:0]      pts;
  logic                  to_flag;
  logic                  ativo, jogada_valida, one_hot, estourou, treino, confere, ultima;
  logic [N_BOTOES-1:0]   jogada;

`ifdef MODO_TREINO_EN
  assign treino = treinamento;
`else
  assign treino = 1'b0;
`endif

  function automatic logic [PTS_W-1:0] soma_sat(input logic [PTS_W-1:0] a, input logic [SUM_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + b;
    return (s > PTS_MAX) ? '1 : s[PTS_W-1:0];
  endfunction

  assign ativo = (estado == ESPERA);

  detector_jogada #(
    .N_BOTOES    (N_BOTOES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_detector (
    .clock         (clock),
    .reset         (reset),
    .ativo         (ativo),
    .botoes        (botoes),
    .jogada_valida (jogada_valida),
    .jogada        (jogada),
    .one_hot       (one_hot),
    .estourou      (estourou)
  );

  assign confere = one_hot && (jogada == mem_dado);
  assign ultima  = ({1'b0, idx} == rod - (ADDR_W + 1)'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIAL;
    else       estado <= prox;
  end

  always_comb begin
    prox = estado;
    unique case (estado)
      INICIAL:    if (jogar) prox = PREPARA;
      PREPARA:    prox = LE_MEM;
      LE_MEM:     prox = ESPERA;
      ESPERA: begin
        // A play landing on the terminal count still wins over the timeout.
        if (jogada_valida) prox = REGISTRA;
        else if (estourou) prox = treino ? REPETE : ERROU;
      end
      REGISTRA:   prox = COMPARA;
      COMPARA: begin
        if (!confere)            prox = treino ? REPETE : ERROU;
        else if (!ultima)        prox = LE_MEM;
        else if (rod < DEPTH_L)  prox = FIM_RODADA;
        else                     prox = ACERTOU;
      end
      FIM_RODADA: prox = LE_MEM;
      REPETE:     prox = LE_MEM;
      ACERTOU:    if (jogar) prox = PREPARA;
      ERROU:      if (jogar) prox = PREPARA;
      default:    prox = INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx     <= '0;
      rod     <= '0;
      pts     <= '0;
      to_flag <= 1'b0;
    end else begin
      case (estado)
        PREPARA: begin
          pts     <= '0;
          rod     <= (ADDR_W + 1)'(1);
          idx     <= '0;
          to_flag <= 1'b0;
        end
        LE_MEM:  to_flag <= 1'b0;
        ESPERA:  if (!jogada_valida && estourou) to_flag <= 1'b1;
        COMPARA: begin
          if (confere) begin
            if (!ultima)             idx <= idx + ADDR_W'(1);
            // Final round credits its own round value plus the completion bonus.
            else if (rod == DEPTH_L) pts <= soma_sat(pts, SUM_W'(rod) + SUM_W'(DEPTH));
          end
        end
        FIM_RODADA: begin
          pts <= soma_sat(pts, SUM_W'(rod));
          rod <= rod + (ADDR_W + 1)'(1);
          idx <= '0;
        end
        REPETE:  idx <= '0;
        default: ;
      endcase
    end
  end

  assign mem_addr  = idx;
  assign rodada    = rod;
  assign pontos    = pts;
  assign db_estado = estado;
  assign acertou   = (estado == ACERTOU);
  assign errou     = (estado == ERROU) || (estado == REPETE);
  assign pronto    = (estado == ACERTOU) || (estado == ERROU);
  assign timeout   = to_flag && errou;

endmodule

// File: tb/tb_motor_rodadas_param.sv
// tb/tb_motor_rodadas_param.sv - randomized self-checking bench for motor_rodadas_param
module tb_motor_rodadas_param;
  localparam int NB = 7, DEPTH = 16, AW = 4, TO = 100, PW = 7;
  localparam int PMAX = (1 << PW) - 1;

  logic          clock = 1'b0, reset = 1'b1, jogar = 1'b0;
  logic [NB-1:0] botoes = '0;
  logic [NB-1:0] mem_dado;
  logic [AW-1:0] mem_addr;
  logic          pronto, acertou, errou, timeout;
  logic [PW-1:0] pontos;
  logic [AW:0]   rodada;
  logic [3:0]    db_estado;
`ifdef MODO_TREINO_EN
  logic          treinamento = 1'b0;
`endif

  logic [NB-1:0] rom [DEPTH];
  int n_cmp = 0, n_err = 0;

  motor_rodadas_param #(.N_BOTOES(NB), .DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT_CYC(TO), .PTS_W(PW)) dut (
    .clock(clock), .reset(reset), .jogar(jogar),
`ifdef MODO_TREINO_EN
    .treinamento(treinamento),
`endif
    .botoes(botoes), .mem_dado(mem_dado), .mem_addr(mem_addr), .pronto(pronto),
    .acertou(acertou), .errou(errou), .timeout(timeout), .pontos(pontos),
    .rodada(rodada), .db_estado(db_estado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) mem_dado <= rom[mem_addr];

  initial begin
    #1000000;
    $display("FAIL watchdog: got no summary, expected completion");
    $fatal(1);
  end

  task automatic chk(string tag, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Score after completing rounds 1..n, plus the bonus on a full win.
  function automatic int pts_ate(int n, bit venceu);
    int s = 0;
    for (int k = 1; k <= n; k++) s += k;
    if (venceu) s += DEPTH;
    return (s > PMAX) ? PMAX : s;
  endfunction

  function automatic logic [NB-1:0] outro_bit(logic [NB-1:0] v);
    int b = 0, s;
    for (int k = 0; k < NB; k++) if (v[k]) b = k;
    s = (b + $urandom_range(1, NB - 1)) % NB;
    return NB'(1) << s;
  endfunction

  task automatic wait_espera(output bit ok, output bit fresh);
    ok = 0; fresh = 0;
    for (int k = 0; k < 20; k++) begin
      if (db_estado == 4'd3) begin ok = 1; break; end
      fresh = 1;
      @(negedge clock);
    end
    if (!ok) chk("espera_alcancada", 0, 1);
  endtask

  task automatic start_game();
    jogar = 1'b1;
    @(negedge clock);
    jogar = 1'b0;
  endtask

  task automatic end_check(int r, bit venceu, bit to);
    chk("pronto", pronto, 1);
    chk("acertou", acertou, venceu);
    chk("errou", errou, !venceu);
    chk("timeout", timeout, to);
    chk("pontos", pontos, pts_ate(venceu ? DEPTH : r - 1, venceu));
    chk("rodada", rodada, r);
  endtask

  // kind: 0 clean win, 1 wrong one-hot, 2 multi-hot, 3 timeout, 4 play on last timeout cycle,
  //       5 reset mid-wait, 6 training-mode wrong play
  task automatic play_game(int fail_r, int fail_i, int kind, logic [NB-1:0] forca);
    bit ok, fresh, falha, fim, pulse;
    logic [NB-1:0] v;
    int d;
    start_game();
    for (int r = 1; r <= DEPTH; r++) begin
      for (int i = 0; i < r; i++) begin
        wait_espera(ok, fresh);
        if (!ok) return;
        chk("rodada_em_jogo", rodada, r);
        chk("mem_addr", mem_addr, i);
        chk("pronto_em_jogo", pronto, 0);
        falha = (r == fail_r) && (i == fail_i);
        if (falha && kind == 5) begin
          @(negedge clock);
          #2 reset = 1'b1;
          #1;
          chk("rst_pronto", pronto, 0); chk("rst_errou", errou, 0); chk("rst_acertou", acertou, 0);
          chk("rst_pontos", pontos, 0); chk("rst_rodada", rodada, 0); chk("rst_estado", db_estado, 0);
          @(negedge clock);
          chk("rst_addr", mem_addr, 0); chk("rst_estado2", db_estado, 0); chk("rst_timeout", timeout, 0);
          reset = 1'b0;
          @(negedge clock);
          return;
        end
        if (falha && kind == 3) begin
          if (fresh) begin
            repeat (TO - 1) @(negedge clock);
            chk("errou_antes_limite", errou, 0);
            @(negedge clock);
          end else begin
            for (int k = 0; k < TO + 10 && !errou; k++) @(negedge clock);
          end
          end_check(r, 0, 1);
          return;
        end
        v = rom[i];
        if (falha && kind == 1) v = (forca != '0) ? forca : outro_bit(v);
        if (falha && kind == 2) v = (forca != '0) ? forca : (v | outro_bit(v));
        if (falha && kind == 6) v = outro_bit(v);
        if (falha && kind == 4) begin
          repeat (TO - 1) @(negedge clock);
        end else begin
          d = $urandom_range(1, 3);
          pulse = ($urandom_range(0, 3) == 0);
          for (int k = 0; k < d; k++) begin
            jogar = pulse && (k == 0);
            @(negedge clock);
          end
          jogar = 1'b0;
        end
        botoes = v;
        repeat (3) @(negedge clock);
        fim = 0;
        if (falha && (kind == 1 || kind == 2)) begin
          end_check(r, 0, 0);
          fim = 1;
`ifdef MODO_TREINO_EN
        end else if (falha && kind == 6) begin
          chk("treino_errou", errou, 1);
          chk("treino_pronto", pronto, 0);
          chk("treino_rodada", rodada, r);
          chk("treino_pontos", pontos, pts_ate(r - 1, 0));
          @(negedge clock);
          chk("treino_pulso", errou, 0);
          i = -1;
`endif
        end else if (r == DEPTH && i == DEPTH - 1) begin
          end_check(DEPTH, 1, 0);
          fim = 1;
        end else begin
          chk("errou_em_jogo", errou, 0);
          chk("timeout_em_jogo", timeout, 0);
          if (i < r - 1) chk("latencia_addr", mem_addr, i + 1);
        end
        repeat ($urandom_range(0, 4)) @(negedge clock);
        botoes = '0;
        @(negedge clock);
        if (fim) return;
      end
    end
  endtask

  initial begin
    int fr, fi, kd;
    rom[0] = 7'h20; rom[1] = 7'h02; rom[2] = 7'h08;
    for (int k = 3; k < DEPTH; k++) rom[k] = NB'(1) << $urandom_range(0, NB - 1);
    repeat (3) @(negedge clock);
    chk("reset_estado", db_estado, 0);
    chk("reset_pronto", pronto, 0);
    chk("reset_pontos", pontos, 0);
    chk("reset_rodada", rodada, 0);
    chk("reset_addr", mem_addr, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("ocioso_sem_jogar", db_estado, 0);

    play_game(DEPTH + 1, 0, 0, '0);
    play_game(2, 1, 1, 7'h04);
    play_game(1, 0, 2, 7'h22);
    play_game(1, 0, 3, '0);
    play_game(1, 0, 4, '0);
    play_game(3, 1, 5, '0);
`ifdef MODO_TREINO_EN
    treinamento = 1'b1;
    play_game(4, 2, 6, '0);
    treinamento = 1'b0;
`endif
    for (int g = 0; g < 8; g++) begin
      kd = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
      fr = $urandom_range(1, DEPTH);
      fi = $urandom_range(0, fr - 1);
      play_game((kd == 0) ? DEPTH + 1 : fr, fi, kd, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
